gate_sweep_checker: RTL and testbench

Self-checking exhaustive stimulus/response engine for N-input combinational or pipelined logic-gate DUTs in the digital-circuit lab designs. It generalises the fixed 2-input AND stimulus/top pairing: it sweeps every input vector, computes the expected result for a selectable gate function, compensates DUT latency, and reports pass/fail, error count and the first failing vector. It sits in bench tops beside the DUT gate and is also synthesisable for on-board self-test.

---
 rtl/gate_pkg.sv | 56 +++++
 rtl/gate_ref_pipe.sv | 73 +++++++
 rtl/gate_sweep_checker.sv | 179 +++++++++++++++++
 tb/tb_gate_sweep_checker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared modes, FSM states and reference gate functions
//
// Purpose : common definitions for the gate sweep checker.
// Contents: MODE_* gate-function codes, state_t FSM encoding,
//           gate_ref() expected-output model, mode_legal() mode filter.
package gate_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NAND = 3'd3;
    localparam logic [2:0] MODE_NOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reduction over the low n bits of vec; the inverted modes are the
    // complement of the full reduction, so n=1 yields buffer / inverter.
    function automatic logic gate_ref(input logic [2:0] mode,
                                      input logic [7:0] vec,
                                      input int         n);
        logic r_and;
        logic r_or;
        logic r_xor;
        logic res;
        r_and = 1'b1;
        r_or  = 1'b0;
        r_xor = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                r_and = r_and & vec[i];
                r_or  = r_or | vec[i];
                r_xor = r_xor ^ vec[i];
            end
        end
        case (mode)
            MODE_AND:  res = r_and;
            MODE_OR:   res = r_or;
            MODE_XOR:  res = r_xor;
            MODE_NAND: res = ~r_and;
            MODE_NOR:  res = ~r_or;
            MODE_XNOR: res = ~r_xor;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic mode_legal(input logic [2:0] mode);
        return mode <= MODE_XNOR;
    endfunction

endpackage

// File: rtl/gate_ref_pipe.sv
// rtl/gate_ref_pipe.sv - LAT-deep delay line of {valid, expected, vector}
//
// Purpose : delays the expected value and its vector so it lines up with a
//           DUT of latency LAT. LAT=0 is a straight wire.
// Ports   : clk, rst_n (async active-low)
//           in_valid / in_exp / in_vec   - entry of the pipe
//           out_valid / out_exp / out_vec - exit of the pipe
module gate_ref_pipe #(
    parameter int LAT  = 0,
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_exp,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    output logic            out_exp,
    output logic [N_IN-1:0] out_vec
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign out_valid = in_valid;
            assign out_exp   = in_exp;
            assign out_vec   = in_vec;
        end else begin : g_regs
            logic [LAT-1:0]  vld_q;
            logic [LAT-1:0]  vld_d;
            logic [LAT-1:0]  exp_q;
            logic [LAT-1:0]  exp_d;
            logic [N_IN-1:0] vec_q [LAT];
            logic [N_IN-1:0] vec_d [LAT];

            always_comb begin
                vld_d    = vld_q;
                exp_d    = exp_q;
                vec_d    = vec_q;
                vld_d[0] = in_valid;
                exp_d[0] = in_exp;
                vec_d[0] = in_vec;
                for (int i = 1; i < LAT; i++) begin
                    vld_d[i] = vld_q[i-1];
                    exp_d[i] = exp_q[i-1];
                    vec_d[i] = vec_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    exp_q <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        vec_q[i] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    exp_q <= exp_d;
                    for (int i = 0; i < LAT; i++) begin
                        vec_q[i] <= vec_d[i];
                    end
                end
            end

            assign out_valid = vld_q[LAT-1];
            assign out_exp   = exp_q[LAT-1];
            assign out_vec   = vec_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive stimulus/response checker for gate DUTs
//
// Purpose : sweeps all 2^N_IN input vectors into a gate DUT, compares its
//           output (LAT cycles later) against the selected gate function and
//           reports pass, error count and the first failing vector.
// Ports   : clk, rst_n (async active-low)
//           start, mode[2:0]          - sweep request and gate function
//           stim[N_IN-1:0], dut_y     - DUT stimulus and DUT response
//           busy, done, pass, bad_mode, err_count[N_IN:0],
//           first_fail_vec[N_IN-1:0], first_fail_valid - status/results
module gate_sweep_checker
    import gate_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int LAT  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      mode,
    output logic [N_IN-1:0] stim,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            bad_mode,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam logic [N_IN:0] ONE = {{N_IN{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [2:0]      mode_q, mode_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            bad_mode_q, bad_mode_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
    logic            ffval_q, ffval_d;

    logic            in_valid;
    logic            in_exp;
    logic            out_valid;
    logic            out_exp;
    logic [N_IN-1:0] out_vec;

    assign in_exp = gate_ref(mode_q, 8'(stim_q), N_IN);

    gate_ref_pipe #(
        .LAT  (LAT),
        .N_IN (N_IN)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_exp    (in_exp),
        .in_vec    (stim_q),
        .out_valid (out_valid),
        .out_exp   (out_exp),
        .out_vec   (out_vec)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        stim_d     = stim_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        bad_mode_d = bad_mode_q;
        err_d      = err_q;
        ffvec_d    = ffvec_q;
        ffval_d    = ffval_q;
        in_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode_legal(mode)) begin
                        mode_d     = mode;
                        cnt_d      = '0;
                        stim_d     = '0;
                        err_d      = '0;
                        ffval_d    = 1'b0;
                        pass_d     = 1'b0;
                        bad_mode_d = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        bad_mode_d = 1'b1;
                        pass_d     = 1'b0;
                        err_d      = '0;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                // cnt_q[N_IN] set means every vector has been issued; stim
                // then parks on all-ones while the pipe drains.
                in_valid = ~cnt_q[N_IN];
                if (!cnt_q[N_IN]) begin
                    cnt_d = cnt_q + ONE;
                    if (!cnt_d[N_IN]) begin
                        stim_d = cnt_d[N_IN-1:0];
                    end
                end
                if (out_valid && (out_exp != dut_y)) begin
                    err_d = err_q + ONE;
                    if (!ffval_q) begin
                        ffval_d = 1'b1;
                        ffvec_d = out_vec;
                    end
                end
                // The all-ones vector is issued exactly once, so its arrival
                // at the pipe exit marks the final comparison.
                if (out_valid && (out_vec == '1)) begin
                    pass_d  = (err_d == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_AND;
            cnt_q      <= '0;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            bad_mode_q <= 1'b0;
            err_q      <= '0;
            ffvec_q    <= '0;
            ffval_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            bad_mode_q <= bad_mode_d;
            err_q      <= err_d;
            ffvec_q    <= ffvec_d;
            ffval_q    <= ffval_d;
        end
    end

    assign stim             = stim_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign bad_mode         = bad_mode_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - self-checking bench for gate_sweep_checker
module tb_gate_sweep_checker;

    logic clk;
    logic rst_n;
    logic start_v [4];
    logic [2:0] mode_v [4];

    wire [1:0] stim_a;
    wire [2:0] stim_b;
    wire [3:0] stim_c;
    wire [3:0] stim_d;
    wire [2:0] err_a;
    wire [3:0] err_b;
    wire [4:0] err_c;
    wire [4:0] err_d;
    wire [1:0] ffv_a;
    wire [2:0] ffv_b;
    wire [3:0] ffv_c;
    wire [3:0] ffv_d;
    logic busy_v [4];
    logic done_v [4];
    logic pass_v [4];
    logic bad_v [4];
    logic ffval_v [4];
    logic [3:0] stim_v [4];
    logic [4:0] err_v [4];
    logic [3:0] ffvec_v [4];

    logic y_a, y_b, y_c, y_d;
    logic r1c, r2c, r1d, r2d;

    int tests = 0;
    int fails = 0;
    int done_cnt2 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT models: combinational AND, stuck-at-0, and two-stage registered XOR.
    assign y_a = &stim_a;
    assign y_b = 1'b0;
    assign y_c = r2c;
    assign y_d = r2d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1c <= 1'b0;
            r2c <= 1'b0;
            r1d <= 1'b0;
            r2d <= 1'b0;
        end else begin
            r1c <= ^stim_c;
            r2c <= r1c;
            r1d <= ^stim_d;
            r2d <= r1d;
        end
    end

    always @(negedge clk) begin
        if (done_v[2]) done_cnt2 = done_cnt2 + 1;
    end

    gate_sweep_checker #(.N_IN(2), .LAT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]),
        .stim(stim_a), .dut_y(y_a), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .bad_mode(bad_v[0]), .err_count(err_a),
        .first_fail_vec(ffv_a), .first_fail_valid(ffval_v[0]));

    gate_sweep_checker #(.N_IN(3), .LAT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]),
        .stim(stim_b), .dut_y(y_b), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .bad_mode(bad_v[1]), .err_count(err_b),
        .first_fail_vec(ffv_b), .first_fail_valid(ffval_v[1]));

    gate_sweep_checker #(.N_IN(4), .LAT(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_v[2]),
        .stim(stim_c), .dut_y(y_c), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .bad_mode(bad_v[2]), .err_count(err_c),
        .first_fail_vec(ffv_c), .first_fail_valid(ffval_v[2]));

    gate_sweep_checker #(.N_IN(4), .LAT(1)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .mode(mode_v[3]),
        .stim(stim_d), .dut_y(y_d), .busy(busy_v[3]), .done(done_v[3]),
        .pass(pass_v[3]), .bad_mode(bad_v[3]), .err_count(err_d),
        .first_fail_vec(ffv_d), .first_fail_valid(ffval_v[3]));

    assign stim_v[0]  = {2'b0, stim_a};
    assign stim_v[1]  = {1'b0, stim_b};
    assign stim_v[2]  = stim_c;
    assign stim_v[3]  = stim_d;
    assign err_v[0]   = {2'b0, err_a};
    assign err_v[1]   = {1'b0, err_b};
    assign err_v[2]   = err_c;
    assign err_v[3]   = err_d;
    assign ffvec_v[0] = {2'b0, ffv_a};
    assign ffvec_v[1] = {1'b0, ffv_b};
    assign ffvec_v[2] = ffv_c;
    assign ffvec_v[3] = ffv_d;

    typedef struct {
        int         inst;
        logic [2:0] md;
        int         exp_cyc;
        logic       exp_pass;
        logic       exp_bad;
        logic [4:0] exp_err;
        logic       chk_ff;
        logic       exp_ffval;
        logic [3:0] exp_ffvec;
        logic [3:0] exp_stim;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulses start for one edge, then counts cycles (sampled on negedges)
    // until done is seen; cyc=1 means done is high right after acceptance.
    task automatic sweep(input int i, input logic [2:0] md, output int cyc);
        @(negedge clk);
        start_v[i] = 1'b1;
        mode_v[i]  = md;
        @(negedge clk);
        start_v[i] = 1'b0;
        cyc = 1;
        while (!done_v[i] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!done_v[i]) begin
            tests++;
            fails++;
            $display("FAIL sweep_timeout inst %0d: got no done, expected done within 200 cycles", i);
        end
    endtask

    initial begin
        int cyc;
        int base;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 3'd0;
        end
        //            inst md cyc pass bad err chk ffval ffvec stim
        tbl[0]  = '{0, 3'd0, 5,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 4'd0, 4'd3};
        tbl[1]  = '{1, 3'd1, 9,  1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 4'd1, 4'd7};
        tbl[2]  = '{2, 3'd2, 19, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 4'd0, 4'd15};
        tbl[3]  = '{3, 3'd2, 18, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1, 4'd1, 4'd15};
        tbl[4]  = '{0, 3'd6, 1,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 4'd0, 4'd3};
        tbl[5]  = '{1, 3'd7, 1,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 4'd0, 4'd7};
        tbl[6]  = '{0, 3'd3, 5,  1'b0, 1'b0, 5'd4,  1'b1, 1'b1, 4'd0, 4'd3};
        tbl[7]  = '{1, 3'd4, 9,  1'b0, 1'b0, 5'd1,  1'b1, 1'b1, 4'd0, 4'd7};
        tbl[8]  = '{1, 3'd2, 9,  1'b0, 1'b0, 5'd4,  1'b1, 1'b1, 4'd1, 4'd7};
        tbl[9]  = '{1, 3'd5, 9,  1'b0, 1'b0, 5'd4,  1'b1, 1'b1, 4'd0, 4'd7};
        tbl[10] = '{1, 3'd0, 9,  1'b0, 1'b0, 5'd1,  1'b1, 1'b1, 4'd7, 4'd7};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_outputs_%0d", i),
                {stim_v[i], busy_v[i], done_v[i], pass_v[i], bad_v[i], err_v[i], ffvec_v[i], ffval_v[i]}, '0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // stim stepping on the 2-input AND sweep
        start_v[0] = 1'b1;
        mode_v[0]  = 3'd0;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stim_step_%0d", k), stim_v[0], k);
            chk($sformatf("busy_step_%0d", k), busy_v[0], 1);
            @(negedge clk);
        end
        chk("step_done", done_v[0], 1);
        chk("step_busy_low", busy_v[0], 0);
        @(negedge clk);

        for (int t = 0; t < 11; t++) begin
            sweep(tbl[t].inst, tbl[t].md, cyc);
            chk($sformatf("v%0d_cycles", t), cyc, tbl[t].exp_cyc);
            chk($sformatf("v%0d_pass", t), pass_v[tbl[t].inst], tbl[t].exp_pass);
            chk($sformatf("v%0d_bad_mode", t), bad_v[tbl[t].inst], tbl[t].exp_bad);
            chk($sformatf("v%0d_err_count", t), err_v[tbl[t].inst], tbl[t].exp_err);
            chk($sformatf("v%0d_stim", t), stim_v[tbl[t].inst], tbl[t].exp_stim);
            chk($sformatf("v%0d_busy", t), busy_v[tbl[t].inst], 0);
            if (tbl[t].chk_ff) begin
                chk($sformatf("v%0d_ff_valid", t), ffval_v[tbl[t].inst], tbl[t].exp_ffval);
                if (tbl[t].exp_ffval)
                    chk($sformatf("v%0d_ff_vec", t), ffvec_v[tbl[t].inst], tbl[t].exp_ffvec);
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_fall", t), done_v[tbl[t].inst], 0);
            chk($sformatf("v%0d_pass_hold", t), pass_v[tbl[t].inst], tbl[t].exp_pass);
        end

        // start during RUN with a different mode is ignored
        base = done_cnt2;
        start_v[2] = 1'b1;
        mode_v[2]  = 3'd2;
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat (3) @(negedge clk);
        start_v[2] = 1'b1;
        mode_v[2]  = 3'd0;
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat (30) @(negedge clk);
        chk("busy_start_done_count", done_cnt2 - base, 1);
        chk("busy_start_pass", pass_v[2], 1);
        chk("busy_start_err", err_v[2], 0);
        chk("busy_start_idle", busy_v[2], 0);

        // reset dropped mid-sweep
        base = done_cnt2;
        start_v[2] = 1'b1;
        mode_v[2]  = 3'd2;
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", busy_v[2], 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs",
            {stim_v[2], busy_v[2], done_v[2], pass_v[2], bad_v[2], err_v[2], ffvec_v[2], ffval_v[2]}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("mid_no_done", done_cnt2 - base, 0);
        chk("mid_still_idle", busy_v[2], 0);
        sweep(2, 3'd2, cyc);
        chk("post_reset_cycles", cyc, 19);
        chk("post_reset_pass", pass_v[2], 1);
        chk("post_reset_err", err_v[2], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
